// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - eight-requester round-robin arbiter with bounded hold time.
//
// A grant is issued from IDLE to the first asserted request found after the
// last-grant pointer (wrapping 7->0). The holder keeps the grant until it
// signals done, drops its request, or has held for HOLD_MAX cycles. Every
// release passes through one IDLE (dead) cycle before the next grant.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [7:0] request lines, bit i = requester i
//   done      in   holder releases the grant this cycle (ignored in IDLE)
//   gnt       out  [7:0] one-hot grant, zero when idle
//   gnt_idx   out  [2:0] binary index of holder, zero when idle
//   gnt_valid out  high while a grant is held
//   timeout   out  one-cycle pulse after a release forced by the hold limit
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Last hold_cnt value allowed before the grant is forcibly withdrawn.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] ptr_q, ptr_d;

    logic [3:0] pick_s;
    logic       holder_req_s;
    logic       hold_hit_s;
    logic       release_s;

    // Round-robin search starting just after p; the pointed-to requester is
    // examined last (offset 8 wraps back to p). Result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] c;
        res = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            c = p + 3'(i);
            if (!res[3] && r[c]) begin
                res = {1'b1, c};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s       = rr_pick(req, ptr_q);
    assign holder_req_s = req[gnt_idx_q];
    assign hold_hit_s   = (hold_cnt_q == HOLD_LAST);
    assign release_s    = done || !holder_req_s || hold_hit_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_s[3]) begin
                    state_d     = BUSY;
                    gnt_idx_d   = pick_s[2:0];
                    gnt_d       = 8'b0000_0001 << pick_s[2:0];
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 4'd0;
                end else begin
                    gnt_d       = 8'b0000_0000;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    state_d     = IDLE;
                    gnt_d       = 8'b0000_0000;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 4'd0;
                    ptr_d       = gnt_idx_q;
                    // A forced release only counts as a timeout when the
                    // holder had not already given the grant up itself.
                    timeout_d   = hold_hit_s && !done && holder_req_s;
                end else if (hold_cnt_q != 4'hF) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'b0000_0000;
                gnt_idx_d   = 3'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 8'b0000_0000;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 4'd0;
            ptr_q       <= 3'd7;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
